// File: rtl/loong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loong_pkg
// Purpose  : Shared definitions for the LOONG round sequencer: controller
//            state encoding, round-index width, round-constant seed and the
//            round-constant LFSR step function.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package loong_pkg;

    localparam int          ROUND_W = 5;
    localparam logic [3:0]  RC_INIT = 4'h1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ARK0  = 3'd2,
        ST_SUB   = 3'd3,
        ST_SHIFT = 3'd4,
        ST_MIX   = 3'd5,
        ST_ARK   = 3'd6,
        ST_DONE  = 3'd7
    } state_e;

    // Maximal-length 4-bit LFSR (period 15): 1,3,7,F,E,D,A,5,B,6,C,9,2,4,8.
    function automatic logic [3:0] rc_next(input logic [3:0] rc);
        return {rc[2:0], rc[3] ^ rc[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/loong_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : loong_round_ctrl_if
// Purpose  : Control/handshake bundle between the LOONG round sequencer and
//            its environment (host start/done, matrix builder load handshake,
//            round-key fetch handshake, datapath layer enables).
// Modports : master - the sequencer (drives status, enables, requests)
//            slave  - the environment (drives start, matrix_done, key_valid)
// Revision : 1.0 - initial release
// ============================================================================
interface loong_round_ctrl_if;
    import loong_pkg::*;

    logic               start;
    logic               busy;
    logic               done;
    logic               err;
    logic               load_req;
    logic               matrix_done;
    logic               key_req;
    logic               key_valid;
    logic               sb_en;
    logic               sr_en;
    logic               mc_en;
    logic               ark_en;
    logic [ROUND_W-1:0] round_idx;
    logic [3:0]         rc;
    logic               last_round;

    modport master (
        input  start, matrix_done, key_valid,
        output busy, done, err, load_req, key_req,
               sb_en, sr_en, mc_en, ark_en, round_idx, rc, last_round
    );

    modport slave (
        output start, matrix_done, key_valid,
        input  busy, done, err, load_req, key_req,
               sb_en, sr_en, mc_en, ark_en, round_idx, rc, last_round
    );

endinterface
`default_nettype wire

// File: rtl/loong_rc_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : loong_rc_lfsr
// Purpose  : 4-bit round-constant LFSR. Loads RC_INIT on init (or reset) and
//            advances one step on step. init has priority over step.
// Ports    : clck - clock (posedge)
//            rst  - synchronous active-high reset
//            init - reload RC_INIT
//            step - advance to the next round constant
//            rc   - current round constant
// Revision : 1.0 - initial release
// ============================================================================
module loong_rc_lfsr
    import loong_pkg::*;
(
    input  wire logic       clck,
    input  wire logic       rst,
    input  wire logic       init,
    input  wire logic       step,
    output logic [3:0]      rc
);

    logic [3:0] rc_q;
    logic [3:0] rc_d;

    always_comb begin
        rc_d = rc_q;
        if (init) begin
            rc_d = RC_INIT;
        end else if (step) begin
            rc_d = rc_next(rc_q);
        end
    end

    always_ff @(posedge clck) begin
        if (rst) begin
            rc_q <= RC_INIT;
        end else begin
            rc_q <= rc_d;
        end
    end

    assign rc = rc_q;

endmodule
`default_nettype wire

// File: rtl/loong_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : loong_round_ctrl
// Purpose  : Round sequencer for the LOONG nibble-cipher datapath. Fires a
//            matrix load, waits for the builder (with timeout), then steps
//            ARK0 followed by NUM_ROUNDS rounds of SUB/SHIFT/MIX/ARK,
//            fetching one round key per ARK and supplying the round constant.
// Ports    : clck - clock (posedge)
//            rst  - synchronous active-high reset
//            bus  - loong_round_ctrl_if.master: start/busy/done/err,
//                   load_req/matrix_done, key_req/key_valid,
//                   sb_en/sr_en/mc_en/ark_en, round_idx, rc, last_round
// Revision : 1.0 - initial release
// ============================================================================
module loong_round_ctrl
    import loong_pkg::*;
#(
    parameter int NUM_ROUNDS   = 16,
    parameter int MC_SKIP_LAST = 1,
    parameter int LOAD_TIMEOUT = 8
) (
    input  wire logic               clck,
    input  wire logic               rst,
    loong_round_ctrl_if.master      bus
);

    localparam int                  LCNT_W    = $clog2(LOAD_TIMEOUT + 1);
    localparam logic [ROUND_W-1:0]  LAST_IDX  = ROUND_W'(NUM_ROUNDS - 1);
    localparam logic [LCNT_W-1:0]   LCNT_LAST = LCNT_W'(LOAD_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [LCNT_W-1:0]  lcnt_q,  lcnt_d;
    logic               err_q,   err_d;

    logic               rc_init;
    logic               rc_step;
    logic               in_round;
    logic               is_last;
    logic               key_phase;
    logic [3:0]         rc_cur;

    // Round-body states are the only ones where last_round may be asserted;
    // ARK0 precedes round 0 and is deliberately excluded.
    assign in_round  = (state_q == ST_SUB) || (state_q == ST_SHIFT) ||
                       (state_q == ST_MIX) || (state_q == ST_ARK);
    assign is_last   = in_round && (round_q == LAST_IDX);
    assign key_phase = (state_q == ST_ARK0) || (state_q == ST_ARK);

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        lcnt_d  = lcnt_q;
        err_d   = err_q;
        rc_init = 1'b0;
        rc_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_LOAD;
                    round_d = '0;
                    lcnt_d  = '0;
                    err_d   = 1'b0;
                    rc_init = 1'b1;
                end
            end
            ST_LOAD: begin
                lcnt_d = lcnt_q + LCNT_W'(1);
                // matrix_done on the final allowed cycle still wins.
                if (bus.matrix_done) begin
                    state_d = ST_ARK0;
                end else if (lcnt_q == LCNT_LAST) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            ST_ARK0: begin
                if (bus.key_valid) begin
                    state_d = ST_SUB;
                end
            end
            ST_SUB: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if ((MC_SKIP_LAST != 0) && is_last) begin
                    state_d = ST_ARK;
                end else begin
                    state_d = ST_MIX;
                end
            end
            ST_MIX: begin
                state_d = ST_ARK;
            end
            ST_ARK: begin
                if (bus.key_valid) begin
                    if (is_last) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SUB;
                        round_d = round_q + ROUND_W'(1);
                        rc_step = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clck) begin
        if (rst) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            lcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            lcnt_q  <= lcnt_d;
            err_q   <= err_d;
        end
    end

    loong_rc_lfsr u_rc_lfsr (
        .clck (clck),
        .rst  (rst),
        .init (rc_init),
        .step (rc_step),
        .rc   (rc_cur)
    );

    // All outputs decode registered state; only ark_en also looks at the
    // key_valid input so the XOR lands in the cycle the key is present.
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.err        = err_q;
    assign bus.load_req   = (state_q == ST_LOAD) && (lcnt_q == '0);
    assign bus.key_req    = key_phase;
    assign bus.ark_en     = key_phase && bus.key_valid;
    assign bus.sb_en      = (state_q == ST_SUB);
    assign bus.sr_en      = (state_q == ST_SHIFT);
    assign bus.mc_en      = (state_q == ST_MIX);
    assign bus.round_idx  = round_q;
    assign bus.rc         = rc_cur;
    assign bus.last_round = is_last;

endmodule
`default_nettype wire

// File: tb/tb_loong_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_loong_round_ctrl
// Purpose  : Scoreboard bench for loong_round_ctrl. dut_a: NUM_ROUNDS=2,
//            MC_SKIP_LAST=1; dut_b: NUM_ROUNDS=16, MC_SKIP_LAST=0. Expected
//            output events (with cycle stamps) are queued at stimulus time
//            and a negedge monitor pops/compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_loong_round_ctrl;

    localparam int EV_LOAD = 0;
    localparam int EV_ARK  = 1;
    localparam int EV_SB   = 2;
    localparam int EV_SR   = 3;
    localparam int EV_MC   = 4;
    localparam int EV_DONE = 5;

    typedef struct {
        int         kind;
        int         cyc;
        logic [4:0] ridx;
        logic [3:0] rc;
        logic       last;
        logic       err;
    } ev_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    ev_t  qa[$];
    ev_t  qb[$];
    int   mc_cnt[2];
    int   ark_cnt[2];
    int   kreq_cnt[2];
    int   busy_cnt[2];
    logic [3:0] last_sb_rc[2];
    logic lr_seen_a = 1'b0;
    logic lr_seen_b = 1'b0;
    bit   md_en_a = 1'b1;
    bit   md_en_b = 1'b1;

    // Hand-listed round constants, round r uses entry r mod 15.
    logic [3:0] rc_tab [15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                                4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};

    loong_round_ctrl_if ifa ();
    loong_round_ctrl_if ifb ();

    loong_round_ctrl #(.NUM_ROUNDS(2), .MC_SKIP_LAST(1), .LOAD_TIMEOUT(8)) dut_a (
        .clck (clk),
        .rst  (rst_a),
        .bus  (ifa.master)
    );

    loong_round_ctrl #(.NUM_ROUNDS(16), .MC_SKIP_LAST(0), .LOAD_TIMEOUT(8)) dut_b (
        .clck (clk),
        .rst  (rst_b),
        .bus  (ifb.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Matrix builder model: answers one cycle after load_req when enabled.
    always @(negedge clk) begin
        lr_seen_a = (ifa.load_req === 1'b1);
        lr_seen_b = (ifb.load_req === 1'b1);
    end

    always @(posedge clk) begin
        #1;
        ifa.matrix_done = md_en_a && lr_seen_a;
        ifb.matrix_done = md_en_b && lr_seen_b;
    end

    function automatic int qsize(input int d);
        return (d == 0) ? qa.size() : qb.size();
    endfunction

    function automatic logic [18:0] pk(input int d);
        if (d == 0)
            return {ifa.busy, ifa.done, ifa.err, ifa.load_req, ifa.key_req, ifa.sb_en,
                    ifa.sr_en, ifa.mc_en, ifa.ark_en, ifa.last_round, ifa.round_idx, ifa.rc};
        return {ifb.busy, ifb.done, ifb.err, ifb.load_req, ifb.key_req, ifb.sb_en,
                ifb.sr_en, ifb.mc_en, ifb.ark_en, ifb.last_round, ifb.round_idx, ifb.rc};
    endfunction

    task automatic pe(input int d, input int kind, input int c, input int r,
                      input logic [3:0] rcv, input logic last, input logic err);
        ev_t e;
        e.kind = kind; e.cyc = c; e.ridx = 5'(r); e.rc = rcv; e.last = last; e.err = err;
        if (d == 0) qa.push_back(e); else qb.push_back(e);
    endtask

    // Expected event timeline of a successful run started in cycle s with
    // matrix_done one cycle after load_req; kdel0 delays round 0's ARK key.
    task automatic gen_run(input int d, input int s, input int n, input bit skip, input int kdel0);
        int t;
        logic last;
        pe(d, EV_LOAD, s + 1, 0, 4'h1, 1'b0, 1'b0);
        pe(d, EV_ARK,  s + 3, 0, 4'h1, 1'b0, 1'b0);
        t = s + 4;
        for (int r = 0; r < n; r++) begin
            last = (r == n - 1);
            pe(d, EV_SB, t,     r, rc_tab[r % 15], last, 1'b0);
            pe(d, EV_SR, t + 1, r, rc_tab[r % 15], last, 1'b0);
            t = t + 2;
            if (!(skip && last)) begin
                pe(d, EV_MC, t, r, rc_tab[r % 15], last, 1'b0);
                t = t + 1;
            end
            if (r == 0) t = t + kdel0;
            pe(d, EV_ARK, t, r, rc_tab[r % 15], last, 1'b0);
            t = t + 1;
        end
        pe(d, EV_DONE, t, n - 1, rc_tab[(n - 1) % 15], 1'b0, 1'b0);
    endtask

    task automatic mon(input int d, input logic sb, input logic sr, input logic mc,
                       input logic ark, input logic ld, input logic dn, input logic er,
                       input logic lst, input logic [4:0] ri, input logic [3:0] rcv);
        int  n;
        int  kind;
        ev_t e;
        n = int'(sb === 1'b1) + int'(sr === 1'b1) + int'(mc === 1'b1) +
            int'(ark === 1'b1) + int'(ld === 1'b1) + int'(dn === 1'b1);
        if (n == 0) return;
        if (mc === 1'b1)  mc_cnt[d]++;
        if (ark === 1'b1) ark_cnt[d]++;
        if (sb === 1'b1)  last_sb_rc[d] = rcv;
        checks++;
        if (n > 1) begin
            failures++;
            $display("FAIL onehot dut%0d cyc=%0d: %0d events high, required 1", d, cyc, n);
            return;
        end
        kind = (ld === 1'b1) ? EV_LOAD : (ark === 1'b1) ? EV_ARK : (sb === 1'b1) ? EV_SB :
               (sr === 1'b1) ? EV_SR : (mc === 1'b1) ? EV_MC : EV_DONE;
        if (qsize(d) == 0) begin
            failures++;
            $display("FAIL unexpected dut%0d cyc=%0d: event kind %0d with nothing expected", d, cyc, kind);
            return;
        end
        if (d == 0) e = qa.pop_front(); else e = qb.pop_front();
        if (kind != e.kind || cyc != e.cyc || ri !== e.ridx || rcv !== e.rc ||
            lst !== e.last || (kind == EV_DONE && er !== e.err)) begin
            failures++;
            $display("FAIL event dut%0d: got kind=%0d cyc=%0d ridx=%0d rc=%h last=%b err=%b, required kind=%0d cyc=%0d ridx=%0d rc=%h last=%b err=%b",
                     d, kind, cyc, ri, rcv, lst, er, e.kind, e.cyc, e.ridx, e.rc, e.last, e.err);
        end
    endtask

    always @(negedge clk) begin
        mon(0, ifa.sb_en, ifa.sr_en, ifa.mc_en, ifa.ark_en, ifa.load_req, ifa.done,
            ifa.err, ifa.last_round, ifa.round_idx, ifa.rc);
        mon(1, ifb.sb_en, ifb.sr_en, ifb.mc_en, ifb.ark_en, ifb.load_req, ifb.done,
            ifb.err, ifb.last_round, ifb.round_idx, ifb.rc);
        if (ifa.key_req === 1'b1) kreq_cnt[0]++;
        if (ifb.key_req === 1'b1) kreq_cnt[1]++;
        if (ifa.busy === 1'b1)    busy_cnt[0]++;
        if (ifb.busy === 1'b1)    busy_cnt[1]++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    task automatic drain(input int d, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (qsize(d) == 0) break;
            step();
        end
        chk($sformatf("drain_dut%0d_pending", d), qsize(d), 0);
        repeat (3) step();
    endtask

    task automatic set_start(input int d, input logic v);
        if (d == 0) ifa.start = v; else ifb.start = v;
    endtask

    localparam logic [18:0] IDLE_OUTS = {10'b0, 5'd0, 4'h1};

    initial begin
        int s;
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.start = 1'b0; ifb.start = 1'b0;
        ifa.key_valid = 1'b1; ifb.key_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mc_cnt[i] = 0; ark_cnt[i] = 0; kreq_cnt[i] = 0; busy_cnt[i] = 0;
            last_sb_rc[i] = 4'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs_a", int'(pk(0)), int'(IDLE_OUTS));
        chk("reset_outs_b", int'(pk(1)), int'(IDLE_OUTS));
        step();
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (2) step();

        // T1: nominal two-round run, hand-listed timeline.
        set_start(0, 1'b1); s = cyc; busy_cnt[0] = 0;
        pe(0, EV_LOAD, s + 1,  0, 4'h1, 1'b0, 1'b0);
        pe(0, EV_ARK,  s + 3,  0, 4'h1, 1'b0, 1'b0);
        pe(0, EV_SB,   s + 4,  0, 4'h1, 1'b0, 1'b0);
        pe(0, EV_SR,   s + 5,  0, 4'h1, 1'b0, 1'b0);
        pe(0, EV_MC,   s + 6,  0, 4'h1, 1'b0, 1'b0);
        pe(0, EV_ARK,  s + 7,  0, 4'h1, 1'b0, 1'b0);
        pe(0, EV_SB,   s + 8,  1, 4'h3, 1'b1, 1'b0);
        pe(0, EV_SR,   s + 9,  1, 4'h3, 1'b1, 1'b0);
        pe(0, EV_ARK,  s + 10, 1, 4'h3, 1'b1, 1'b0);
        pe(0, EV_DONE, s + 11, 1, 4'h3, 1'b0, 1'b0);
        step(); set_start(0, 1'b0);
        drain(0, 40);
        chk("t1_busy_cycles", busy_cnt[0], 11);

        // T2: load timeout, no builder response.
        md_en_a = 1'b0;
        set_start(0, 1'b1); s = cyc;
        pe(0, EV_LOAD, s + 1, 0, 4'h1, 1'b0, 1'b0);
        pe(0, EV_DONE, s + 9, 0, 4'h1, 1'b0, 1'b1);
        step(); set_start(0, 1'b0);
        drain(0, 40);
        chk("t2_err_held", int'(ifa.err), 1);
        chk("t2_busy_idle", int'(ifa.busy), 0);
        md_en_a = 1'b1;

        // T3: start pulses in SUB and DONE are ignored; err cleared by start.
        set_start(0, 1'b1); s = cyc;
        gen_run(0, s, 2, 1'b1, 0);
        step(); set_start(0, 1'b0);
        @(negedge clk);
        chk("t3_err_cleared", int'(ifa.err), 0);
        goto(s + 4);  set_start(0, 1'b1);
        goto(s + 5);  set_start(0, 1'b0);
        goto(s + 11); set_start(0, 1'b1);
        goto(s + 12); set_start(0, 1'b0);
        drain(0, 40);
        set_start(0, 1'b1); s = cyc;
        gen_run(0, s, 2, 1'b1, 0);
        step(); set_start(0, 1'b0);
        drain(0, 40);

        // T4: key_valid low for 5 cycles of round 0 ARK.
        kreq_cnt[0] = 0;
        set_start(0, 1'b1); s = cyc;
        gen_run(0, s, 2, 1'b1, 5);
        step(); set_start(0, 1'b0);
        goto(s + 4);  ifa.key_valid = 1'b0;
        goto(s + 12); ifa.key_valid = 1'b1;
        drain(0, 40);
        chk("t4_key_req_cycles", kreq_cnt[0], 8);

        // T5: reset during MIX of round 3 on the 16-round instance.
        set_start(1, 1'b1); s = cyc;
        gen_run(1, s, 16, 1'b0, 0);
        while (qb.size() > 17) void'(qb.pop_back());
        step(); set_start(1, 1'b0);
        goto(s + 18); rst_b = 1'b1;
        goto(s + 19); rst_b = 1'b0;
        @(negedge clk);
        chk("t5_outs_after_rst", int'(pk(1)), int'(IDLE_OUTS));
        chk("t5_events_consumed", qb.size(), 0);
        repeat (6) step();

        // T6: full 16-round run, MIX in every round.
        mc_cnt[1] = 0; ark_cnt[1] = 0;
        set_start(1, 1'b1); s = cyc;
        gen_run(1, s, 16, 1'b0, 0);
        step(); set_start(1, 1'b0);
        drain(1, 200);
        chk("t6_mc_pulses", mc_cnt[1], 16);
        chk("t6_ark_pulses", ark_cnt[1], 17);
        // Period-15 LFSR wraps: round 15 reuses round 0's constant.
        chk("t6_rc_round15", int'(last_sb_rc[1]), 4'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
